// File: rtl/gemm_pkg.sv
// Shared definitions for the 4x4 systolic GEMM slice.
//   N          : array dimension (rows = cols = inner tile depth)
//   DW         : signed operand width
//   data_t     : one signed operand
//   row_vec_t  : N operands packed, element m in bits [m*DW +: DW]
//   feeder_state_e : control states of the skew feeder
package gemm_pkg;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    typedef logic signed [DW-1:0] data_t;
    typedef data_t [N-1:0]        row_vec_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/skew_tile_buffer.sv
// N x N operand store for one matrix tile with a diagonal read port.
//   clk_i     : clock
//   wr_en_i   : write row wr_idx_i with wr_row_i
//   wr_idx_i  : row index k being loaded
//   wr_row_i  : row k, element m in bits [m*DW +: DW]
//   step_i    : diagonal feed step f (0..2N-2)
//   diag_o    : lane l in bits [l*DW +: DW]
// Row mode   (COL_MODE=0): lane i = M[i][f-i], 0 outside the tile.
// Column mode(COL_MODE=1): lane j = M[f-j][j], 0 outside the tile.
// Contents are not reset; they are always rewritten before being read.
module skew_tile_buffer
    import gemm_pkg::*;
#(
    parameter int unsigned N        = gemm_pkg::N,
    parameter int unsigned DW       = gemm_pkg::DW,
    parameter int unsigned IW       = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned SW       = (2*N-1 > 1) ? $clog2(2*N-1) : 1,
    parameter bit          COL_MODE = 1'b0
)(
    input  logic            clk_i,
    input  logic            wr_en_i,
    input  logic [IW-1:0]   wr_idx_i,
    input  logic [N*DW-1:0] wr_row_i,
    input  logic [SW-1:0]   step_i,
    output logic [N*DW-1:0] diag_o
);

    logic [N*DW-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_row_i;
        end
    end

    // Lane l carries inner index kk where f = l + kk; a step that falls
    // outside 0..N-1 for that lane matches no kk and leaves the lane at zero.
    always_comb begin
        diag_o = '0;
        for (int unsigned l = 0; l < N; l++) begin
            for (int unsigned kk = 0; kk < N; kk++) begin
                if (32'(step_i) == l + kk) begin
                    if (COL_MODE) begin
                        diag_o[l*DW +: DW] = mem_q[IW'(kk)][l*DW +: DW];
                    end else begin
                        diag_o[l*DW +: DW] = mem_q[IW'(l)][kk*DW +: DW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder of the NxN systolic GEMM array.
// Loads one A tile and one B tile (N beats, one row of each per beat),
// then drives diagonal-skewed row/column streams for 2N-1 steps, waits
// DRAIN_CYCLES for the array to settle and pulses done.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : load beat valid
//   in_ready    : load beat ready (high only in LOAD, state-decoded)
//   in_a_row    : A row k, element m in bits [m*DW +: DW]
//   in_b_row    : B row k, element m in bits [m*DW +: DW]
//   row_out     : row-stream i in slice i, A[i][f-i]
//   col_out     : column-stream j in slice j, B[f-j][j]
//   feed_valid  : a feed step is on row_out/col_out
//   busy        : feeding or draining
//   done        : one-cycle pulse, tile results final in the array
module systolic_skew_feeder
    import gemm_pkg::*;
#(
    parameter int unsigned N            = gemm_pkg::N,
    parameter int unsigned DW           = gemm_pkg::DW,
    parameter int unsigned DRAIN_CYCLES = N + 1
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a_row,
    input  logic [N*DW-1:0] in_b_row,
    output logic [N*DW-1:0] row_out,
    output logic [N*DW-1:0] col_out,
    output logic            feed_valid,
    output logic            busy,
    output logic            done
);

    localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW  = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [KW-1:0]  LAST_BEAT  = KW'(N - 1);
    localparam logic [SW-1:0]  LAST_STEP  = SW'(2*N - 2);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);

    feeder_state_e   state_q, state_d;
    logic [KW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   step_q, step_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [N*DW-1:0] row_q, row_d;
    logic [N*DW-1:0] col_q, col_d;
    logic            feed_valid_q, feed_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            wr_en;
    logic [N*DW-1:0] a_diag;
    logic [N*DW-1:0] b_diag;

    skew_tile_buffer #(
        .N        (N),
        .DW       (DW),
        .IW       (KW),
        .SW       (SW),
        .COL_MODE (1'b0)
    ) u_a_buf (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_idx_i (beat_q),
        .wr_row_i (in_a_row),
        .step_i   (step_q),
        .diag_o   (a_diag)
    );

    skew_tile_buffer #(
        .N        (N),
        .DW       (DW),
        .IW       (KW),
        .SW       (SW),
        .COL_MODE (1'b1)
    ) u_b_buf (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_idx_i (beat_q),
        .wr_row_i (in_b_row),
        .step_i   (step_q),
        .diag_o   (b_diag)
    );

    // Ready depends on state only, so in_valid never reaches in_ready.
    assign in_ready = (state_q == LOAD);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        step_d       = step_q;
        drain_d      = drain_q;
        row_d        = '0;
        col_d        = '0;
        feed_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        wr_en        = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        step_d  = '0;
                        state_d = FEED;
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end
            end

            // Output registers are loaded from step_q, so step f appears
            // one edge after the state register reaches that step.
            FEED: begin
                feed_valid_d = 1'b1;
                busy_d       = 1'b1;
                row_d        = a_diag;
                col_d        = b_diag;
                if (step_q == LAST_STEP) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end

            // busy drops on the same edge that raises done.
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    done_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    busy_d  = 1'b1;
                    drain_d = drain_q + DCW'(1);
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            beat_q       <= '0;
            step_q       <= '0;
            drain_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            feed_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            step_q       <= step_d;
            drain_q      <= drain_d;
            row_q        <= row_d;
            col_q        <= col_d;
            feed_valid_q <= feed_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign row_out    = row_q;
    assign col_out    = col_q;
    assign feed_valid = feed_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
